pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into one stall vector.
- Times multi-cycle EX operations with an internal down-counter.
- Issues registered flush pulses with a redirect PC.
- The ID decode stage, the EX ALU and the pipeline registers between them all take their hold/flush control from this block.

---
 rtl/pipe_ctrl_if.sv | 52 +++++
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline control bus between the core stages and pipe_ctrl
//
// Purpose: groups the stall/multi-cycle/flush request and control signals.
//   master : core side, drives requests and observes hold/flush controls
//   slave  : pipe_ctrl side
// Signals:
//   stallreq_if/id/ex  per-stage hold requests
//   mc_start/mc_cycles multi-cycle EX start pulse and length
//   flush_req/flush_pc redirect request and target
//   stall_o[5:0]       hold vector {WB,MEM,EX,ID,IF,PC}
//   flush_o/new_pc_o   one-cycle flush pulse and redirect PC
//   mc_busy_o/mc_done_o multi-cycle status
//   perf_stall_cnt_o   stall counter (only with PIPE_CTRL_PERF_EN)
interface pipe_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             mc_start;
  logic [CNT_W-1:0] mc_cycles;
  logic             flush_req;
  logic [31:0]      flush_pc;
  logic [5:0]       stall_o;
  logic             flush_o;
  logic [31:0]      new_pc_o;
  logic             mc_busy_o;
  logic             mc_done_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]      perf_stall_cnt_o;
`endif

`ifdef PIPE_CTRL_PERF_EN
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, mc_start, mc_cycles, flush_req, flush_pc,
    input  stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o, perf_stall_cnt_o
  );
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, mc_start, mc_cycles, flush_req, flush_pc,
    output stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o, perf_stall_cnt_o
  );
`else
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, mc_start, mc_cycles, flush_req, flush_pc,
    input  stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o
  );
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, mc_start, mc_cycles, flush_req, flush_pc,
    output stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o
  );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline sequencing controller (stall merge, multi-cycle timer, flush)
//
// Purpose: merges per-stage stall requests into one hold vector, times
//   multi-cycle EX operations with a down-counter and issues registered
//   flush pulses carrying a redirect PC.
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset
//   bus  pipe_ctrl_if.slave (requests in, stall/flush/multi-cycle status out)
// Optional: define PIPE_CTRL_PERF_EN to add bus.perf_stall_cnt_o, a 32-bit
//   count of clock edges on which the PC stage was held.
module pipe_ctrl #(
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q;
  logic [31:0]      new_pc_q;
  logic [5:0]       stall;
  logic             mc_valid;
  logic             mc_last;
  logic             ex_hold;

  assign mc_valid = bus.mc_start && (bus.mc_cycles != '0);
  // cnt==1 is the cycle the result appears, so EX is released there.
  assign mc_last  = (state_q == MULTI) && (cnt_q == CNT_W'(1));

  // Start cycle stalls even if a flush arrives alongside; the flush pulse
  // of the next cycle clears the pipeline anyway.
  assign ex_hold = bus.stallreq_ex
                || ((state_q == RUN) && mc_valid)
                || ((state_q == MULTI) && !mc_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= bus.flush_req;
      if (bus.flush_req) begin
        new_pc_q <= bus.flush_pc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush_req) begin
      // Redirect aborts any pending multi-cycle op without a done pulse.
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mc_valid) begin
            state_d = MULTI;
            cnt_d   = bus.mc_cycles;
          end
        end
        MULTI: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (mc_last) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall = 6'b000000;
    if (rst || flush_q) begin
      stall = 6'b000000;
    end else if (ex_hold) begin
      stall = 6'b001111;
    end else if (bus.stallreq_id) begin
      stall = 6'b000111;
    end else if (bus.stallreq_if) begin
      stall = 6'b000011;
    end
  end

  assign bus.stall_o   = stall;
  assign bus.flush_o   = flush_q;
  assign bus.new_pc_o  = new_pc_q;
  assign bus.mc_busy_o = (state_q == MULTI);
  assign bus.mc_done_o = mc_last;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= 32'h0;
    end else if (stall[0]) begin
      perf_q <= perf_q + 32'h1;
    end
  end

  assign bus.perf_stall_cnt_o = perf_q;
`else
  // Stall counter not built.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  // Reference model: a multi-cycle op accepted in cycle m_s with length m_n
  // keeps the unit busy in cycles m_s+1 .. m_s+m_n, result in m_s+m_n.
  int          m_cyc = 0;
  int          m_s   = -1;
  int          m_n   = 0;
  bit          m_flush = 1'b0;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_perf = 32'h0;

  pipe_ctrl_if #(.CNT_W(6)) bus ();

  pipe_ctrl #(.CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s     = -1;
    m_n     = 0;
    m_flush = 1'b0;
    m_pc    = 32'h0;
    m_perf  = 32'h0;
  endtask

  task automatic step(input bit rif, input bit rid, input bit rex, input bit ms,
                      input logic [5:0] mn, input bit fr, input logic [31:0] fpc);
    bit busy, done, hold, accept;
    logic [5:0] es;
    @(negedge clk);
    bus.stallreq_if = rif;
    bus.stallreq_id = rid;
    bus.stallreq_ex = rex;
    bus.mc_start    = ms;
    bus.mc_cycles   = mn;
    bus.flush_req   = fr;
    bus.flush_pc    = fpc;
    #1;
    busy   = (m_s >= 0) && (m_cyc > m_s) && (m_cyc <= m_s + m_n);
    done   = busy && (m_cyc == m_s + m_n);
    accept = !busy && ms && (mn != 0);
    hold   = rex || accept || (busy && !done);
    if (m_flush)  es = 6'b000000;
    else if (hold) es = 6'b001111;
    else if (rid)  es = 6'b000111;
    else if (rif)  es = 6'b000011;
    else           es = 6'b000000;
    chk("stall_o",   {26'h0, bus.stall_o}, {26'h0, es});
    chk("flush_o",   {31'h0, bus.flush_o}, {31'h0, m_flush});
    chk("new_pc_o",  bus.new_pc_o, m_pc);
    chk("mc_busy_o", {31'h0, bus.mc_busy_o}, {31'h0, busy});
    chk("mc_done_o", {31'h0, bus.mc_done_o}, {31'h0, done});
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_cnt", bus.perf_stall_cnt_o, m_perf);
`endif
    if (es[0]) m_perf = m_perf + 32'h1;
    if (fr) begin
      m_s = -1;
      m_flush = 1'b1;
      m_pc = fpc;
    end else begin
      m_flush = 1'b0;
      if (done) m_s = -1;
      else if (accept) begin
        m_s = m_cyc;
        m_n = int'(mn);
      end
    end
    m_cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 6'd0, 0, 32'h0);
  endtask

  initial begin
    bus.stallreq_if = 1'b0;
    bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0;
    bus.mc_start    = 1'b1;
    bus.mc_cycles   = 6'd3;
    bus.flush_req   = 1'b0;
    bus.flush_pc    = 32'h0;
    repeat (2) @(posedge clk);
    // In reset with a live mc_start, outputs must still be zero.
    #1;
    chk("rst_stall",  {26'h0, bus.stall_o}, 32'h0);
    chk("rst_flush",  {31'h0, bus.flush_o}, 32'h0);
    chk("rst_new_pc", bus.new_pc_o, 32'h0);
    chk("rst_busy",   {31'h0, bus.mc_busy_o}, 32'h0);
    chk("rst_done",   {31'h0, bus.mc_done_o}, 32'h0);
    bus.mc_start  = 1'b0;
    bus.mc_cycles = 6'd0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    idle();
    idle();

    // Stall priority
    step(1, 0, 0, 0, 6'd0, 0, 32'h0);
    step(1, 1, 0, 0, 6'd0, 0, 32'h0);
    step(1, 1, 1, 0, 6'd0, 0, 32'h0);
    idle();

    // Multi-cycle N=3, N=1, N=0
    step(0, 0, 0, 1, 6'd3, 0, 32'h0);
    repeat (4) idle();
    step(0, 0, 0, 1, 6'd1, 0, 32'h0);
    repeat (2) idle();
    step(0, 0, 0, 1, 6'd0, 0, 32'h0);
    repeat (2) idle();

    // mc_start while busy is ignored; stage requests during MULTI
    step(0, 0, 0, 1, 6'd4, 0, 32'h0);
    step(0, 0, 0, 1, 6'd9, 0, 32'h0);
    step(0, 1, 0, 0, 6'd0, 0, 32'h0);
    step(1, 0, 1, 0, 6'd0, 0, 32'h0);
    step(0, 1, 0, 0, 6'd0, 0, 32'h0);
    repeat (2) idle();

    // N=5 aborted by flush in C2
    step(0, 0, 0, 1, 6'd5, 0, 32'h0);
    idle();
    step(0, 0, 0, 0, 6'd0, 1, 32'h0000_0100);
    repeat (6) idle();

    // Flush and mc_start together; back-to-back flushes
    step(0, 0, 0, 1, 6'd3, 1, 32'h0000_0200);
    step(0, 0, 0, 0, 6'd0, 1, 32'h0000_0300);
    step(1, 0, 0, 0, 6'd0, 1, 32'hdead_beef);
    repeat (3) idle();

    // Max length
    step(0, 0, 0, 1, 6'd63, 0, 32'h0);
    repeat (64) idle();

    // Async reset mid-MULTI
    step(0, 0, 0, 1, 6'd5, 0, 32'h0);
    idle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("amid_stall", {26'h0, bus.stall_o}, 32'h0);
    chk("amid_busy",  {31'h0, bus.mc_busy_o}, 32'h0);
    chk("amid_done",  {31'h0, bus.mc_done_o}, 32'h0);
    chk("amid_pc",    bus.new_pc_o, 32'h0);
    chk("amid_flush", {31'h0, bus.flush_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // 4 stall cycles then 2 free
    repeat (4) step(1, 0, 0, 0, 6'd0, 0, 32'h0);
    repeat (2) idle();
`ifdef PIPE_CTRL_PERF_EN
    #1 chk("perf_4", bus.perf_stall_cnt_o, 32'd4);
`endif
    idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rif, rid, rex, ms, fr;
      logic [5:0] mn;
      rif = ($urandom_range(0, 3) == 0);
      rid = ($urandom_range(0, 5) == 0);
      rex = ($urandom_range(0, 7) == 0);
      ms  = ($urandom_range(0, 4) == 0);
      fr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) mn = 6'd63;
      else mn = 6'($urandom_range(0, 7));
      step(rif, rid, rex, ms, mn, fr, $urandom);
    end
    repeat (70) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
